lcd_display: RTL and testbench

//  Character-LCD driver (HD44780-compatible, 8-bit bus, write-only) that fills the display stage of the

---
 rtl/lcd_display.sv | 241 ++++++++++++++++++++++++
 tb/tb_lcd_display.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display.sv
// lcd_display: HD44780-compatible 8-bit write-only character LCD driver. It runs the power-up init, then rewrites only changed digits.
// Optional busy indicator at DDRAM 0x0F, enabled by defining LCD_DISPLAY_BUSY_IND_EN.
module lcd_display #(
    parameter int PWR_WAIT = 750000,
    parameter int E_PULSE  = 25,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic [1:0] num,
    input  logic [3:0] lcd_num,
    input  logic       busy,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);
    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_DIG_ADDR, S_DIG_DATA, S_BSY_ADDR, S_BSY_DATA
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_E, PH_HOLD, PH_WAIT} phase_t;

    function automatic logic [7:0] char_of(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : 8'h20;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [19:0]     cnt_q, cnt_d;
    logic [2:0]      init_idx_q, init_idx_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [1:0]      req_num_q, req_num_d;
    logic [3:0]      req_val_q, req_val_d;
    logic            lcd_e_q, lcd_e_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic [7:0]      lcd_db_q, lcd_db_d;
    logic            ready_q, ready_d;

    logic            in_write;
    logic            wr_done;
    logic            start_wr;
    logic            wr_rs;
    logic [7:0]      wr_db;

`ifdef LCD_DISPLAY_BUSY_IND_EN
    logic            busy_sh_q, busy_sh_d;
    logic            req_busy_q, req_busy_d;
`else
    logic            unused_busy;
    assign unused_busy = busy;
`endif

    assign in_write = (state_q != S_PWR) && (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        shadow_d   = shadow_q;
        req_num_d  = req_num_q;
        req_val_d  = req_val_q;
        lcd_e_d    = lcd_e_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_db_d   = lcd_db_q;
        wr_done    = 1'b0;
        start_wr   = 1'b0;
        wr_rs      = 1'b0;
        wr_db      = 8'h00;
`ifdef LCD_DISPLAY_BUSY_IND_EN
        busy_sh_d  = busy_sh_q;
        req_busy_d = req_busy_q;
`endif

        // Shared byte-write engine: setup, E high, hold, then post-write wait.
        if (in_write) begin
            case (phase_q)
                PH_SETUP: begin
                    lcd_e_d = 1'b1;
                    phase_d = PH_E;
                    cnt_d   = 20'(E_PULSE - 1);
                end
                PH_E: begin
                    if (cnt_q == 20'd0) begin
                        lcd_e_d = 1'b0;
                        phase_d = PH_HOLD;
                    end else begin
                        cnt_d = cnt_q - 20'd1;
                    end
                end
                PH_HOLD: begin
                    phase_d = PH_WAIT;
                    cnt_d   = (!lcd_rs_q && lcd_db_q == 8'h01) ? 20'(CLR_WAIT - 1)
                                                               : 20'(CMD_WAIT - 1);
                end
                default: begin
                    if (cnt_q == 20'd0) wr_done = 1'b1;
                    else                cnt_d   = cnt_q - 20'd1;
                end
            endcase
        end

        case (state_q)
            S_PWR: begin
                if (cnt_q == 20'(PWR_WAIT - 1)) begin
                    state_d    = S_INIT;
                    init_idx_d = 3'd0;
                    start_wr   = 1'b1;
                    wr_db      = init_cmd(3'd0);
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_INIT: begin
                if (wr_done) begin
                    if (init_idx_q == 3'd5) begin
                        state_d = S_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        start_wr   = 1'b1;
                        wr_db      = init_cmd(init_idx_q + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                // Compare displayed characters, so any blank code matches a blank shadow.
                if (lcd_en && char_of(lcd_num) != char_of(shadow_q[num])) begin
                    req_num_d = num;
                    req_val_d = lcd_num;
                    state_d   = S_DIG_ADDR;
                    start_wr  = 1'b1;
                    wr_db     = 8'h80 | {6'b0, num};
                end
`ifdef LCD_DISPLAY_BUSY_IND_EN
                else if (busy != busy_sh_q) begin
                    req_busy_d = busy;
                    state_d    = S_BSY_ADDR;
                    start_wr   = 1'b1;
                    wr_db      = 8'h8F;
                end
`endif
            end
            S_DIG_ADDR: begin
                if (wr_done) begin
                    state_d  = S_DIG_DATA;
                    start_wr = 1'b1;
                    wr_rs    = 1'b1;
                    wr_db    = char_of(req_val_q);
                end
            end
            S_DIG_DATA: begin
                if (wr_done) begin
                    shadow_d[req_num_q] = req_val_q;
                    state_d             = S_IDLE;
                end
            end
`ifdef LCD_DISPLAY_BUSY_IND_EN
            S_BSY_ADDR: begin
                if (wr_done) begin
                    state_d  = S_BSY_DATA;
                    start_wr = 1'b1;
                    wr_rs    = 1'b1;
                    wr_db    = req_busy_q ? 8'h42 : 8'h20;
                end
            end
            S_BSY_DATA: begin
                if (wr_done) begin
                    busy_sh_d = req_busy_q;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: state_d = S_PWR;
        endcase

        if (start_wr) begin
            lcd_rs_d = wr_rs;
            lcd_db_d = wr_db;
            lcd_e_d  = 1'b0;
            phase_d  = PH_SETUP;
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWR;
            phase_q    <= PH_SETUP;
            cnt_q      <= 20'd0;
            init_idx_q <= 3'd0;
            shadow_q   <= '1;
            req_num_q  <= 2'd0;
            req_val_q  <= 4'd0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_db_q   <= 8'h00;
            ready_q    <= 1'b0;
`ifdef LCD_DISPLAY_BUSY_IND_EN
            busy_sh_q  <= 1'b0;
            req_busy_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            shadow_q   <= shadow_d;
            req_num_q  <= req_num_d;
            req_val_q  <= req_val_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_db_q   <= lcd_db_d;
            ready_q    <= ready_d;
`ifdef LCD_DISPLAY_BUSY_IND_EN
            busy_sh_q  <= busy_sh_d;
            req_busy_q <= req_busy_d;
`endif
        end
    end

    assign ready  = ready_q;
    assign lcd_rs = lcd_rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_e  = lcd_e_q;
    assign lcd_db = lcd_db_q;

endmodule

// File: tb/tb_lcd_display.sv
// Bench for lcd_display: the monitor captures every E pulse, and a character-level display model predicts the writes.
`timescale 1ns/1ps
module tb_lcd_display;
    localparam int PWR_WAIT = 100;
    localparam int E_PULSE  = 2;
    localparam int CMD_WAIT = 5;
    localparam int CLR_WAIT = 10;
    localparam int WR_CMD   = 2 + E_PULSE + CMD_WAIT;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       lcd_en = 1'b0;
    logic [1:0] num    = 2'd0;
    logic [3:0] lcd_num = 4'd0;
    logic       busy   = 1'b0;
    logic       ready, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    int total = 0;
    int bad   = 0;

    lcd_display #(.PWR_WAIT(PWR_WAIT), .E_PULSE(E_PULSE), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .lcd_en(lcd_en), .num(num), .lcd_num(lcd_num),
        .busy(busy), .ready(ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    initial forever #5 sysclk = ~sysclk;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         start;
        int         width;
        bit         stable;
        logic       rdy;
    } pulse_t;

    pulse_t     pq[$];
    bit         in_p;
    int         cyc, rel_cyc, rdy_rise;
    logic [7:0] disp[4];
    logic       bsh;

    // Reference character map: digits 0..9 display as ASCII, all other codes display as a blank.
    function automatic logic [7:0] ch(input logic [3:0] v);
        return (v <= 4'd9) ? 8'd48 + 8'(v) : 8'd32;
    endfunction

    initial begin
        pulse_t cur;
        bit prev_rst, prev_rdy;
        prev_rst = 0; prev_rdy = 0;
        cur = '{rs: 1'b0, db: 8'h00, start: 0, width: 0, stable: 1'b0, rdy: 1'b0};
        forever begin
            @(negedge sysclk);
            cyc++;
            if (rst_n && !prev_rst) rel_cyc = cyc;
            if (ready && !prev_rdy) rdy_rise = cyc;
            prev_rst = rst_n;
            prev_rdy = ready;
            if (!rst_n) in_p = 0;
            else if (lcd_e && !in_p) begin
                in_p = 1; cur.rs = lcd_rs; cur.db = lcd_db; cur.start = cyc;
                cur.width = 1; cur.stable = 1; cur.rdy = ready;
            end else if (lcd_e) begin
                cur.width++;
                if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 0;
            end else if (in_p) begin
                in_p = 0;
                if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 0;
                pq.push_back(cur);
            end
        end
    end

    // Wait until the driver sits idle for several cycles in a row.
    task automatic settle(output bit ok);
        int run;
        run = 0; ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sysclk);
            if (ready === 1'b1 && lcd_e === 1'b0) run++; else run = 0;
            if (run >= 4) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, lcd_rs, lcd_rw, lcd_e, lcd_db} !== 12'h000)
            begin bad++; $display("FAIL reset_outs got=%h exp=000", {ready, lcd_rs, lcd_rw, lcd_e, lcd_db}); end
    endtask

    task automatic test_init();
        logic [8:0] exp[$];
        bit ok;
        exp = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
        pq.delete();
        @(negedge sysclk); #2 rst_n = 1'b1;
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL init_timeout got=0 exp=1"); end
        total++; if (pq.size() != 6) begin bad++; $display("FAIL init_count got=%0d exp=6", pq.size()); end
        if (pq.size() > 0) begin
            total++;
            if (pq[0].start - rel_cyc != PWR_WAIT)
                begin bad++; $display("FAIL init_pwr_wait got=%0d exp=%0d", pq[0].start - rel_cyc, PWR_WAIT); end
        end
        foreach (exp[i]) if (i < pq.size()) begin
            total++;
            if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE || !pq[i].stable || pq[i].rdy !== 1'b0)
                begin bad++; $display("FAIL init_pulse%0d got=%h w=%0d st=%0d rdy=%b exp=%h", i, {pq[i].rs, pq[i].db}, pq[i].width, pq[i].stable, pq[i].rdy, exp[i]); end
            if (i > 0) begin
                total++;
                if (pq[i].start - pq[i-1].start != 2 + E_PULSE + ((exp[i-1] == 9'h001) ? CLR_WAIT : CMD_WAIT))
                    begin bad++; $display("FAIL init_gap%0d got=%0d", i, pq[i].start - pq[i-1].start); end
            end
        end
        if (pq.size() == 6) begin
            total++;
            if (rdy_rise - pq[5].start != 1 + E_PULSE + CMD_WAIT)
                begin bad++; $display("FAIL init_ready got=%0d exp=%0d", rdy_rise - pq[5].start, 1 + E_PULSE + CMD_WAIT); end
        end
        for (int i = 0; i < 4; i++) disp[i] = 8'h20;
        bsh = 1'b0;
        pq.delete();
    endtask

    task automatic test_digit();
        logic [8:0] exp[$];
        bit ok;
        exp = '{9'h082, 9'h137};
        lcd_en = 1'b1; num = 2'd2; lcd_num = 4'd7;
        settle(ok);
        total++; if (!ok || pq.size() != 2) begin bad++; $display("FAIL digit_count got=%0d exp=2 ok=%0d", pq.size(), ok); end
        foreach (exp[i]) if (i < pq.size()) begin
            total++;
            if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE || !pq[i].stable || pq[i].rdy !== 1'b0)
                begin bad++; $display("FAIL digit_pulse%0d got=%h w=%0d rdy=%b exp=%h", i, {pq[i].rs, pq[i].db}, pq[i].width, pq[i].rdy, exp[i]); end
        end
        if (pq.size() == 2) begin
            total++;
            if (pq[1].start - pq[0].start != WR_CMD) begin bad++; $display("FAIL digit_gap got=%0d exp=%0d", pq[1].start - pq[0].start, WR_CMD); end
        end
        disp[2] = 8'h37;
        pq.delete();
        repeat (100) @(negedge sysclk);
        total++;
        if (pq.size() != 0 || ready !== 1'b1) begin bad++; $display("FAIL digit_hold got=%0d/%b exp=0/1", pq.size(), ready); end
    endtask

    task automatic test_disabled();
        logic [8:0] exp[$];
        bit ok;
        int lows;
        exp = '{9'h081, 9'h134};
        lows = 0;
        lcd_en = 1'b0; num = 2'd1; lcd_num = 4'd4;
        repeat (200) begin @(negedge sysclk); if (ready !== 1'b1) lows++; end
        total++;
        if (pq.size() != 0 || lows != 0) begin bad++; $display("FAIL disabled_quiet got=%0d/%0d exp=0/0", pq.size(), lows); end
        lcd_en = 1'b1;
        settle(ok);
        total++; if (!ok || pq.size() != 2) begin bad++; $display("FAIL enable_count got=%0d exp=2", pq.size()); end
        foreach (exp[i]) if (i < pq.size()) begin
            total++;
            if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE)
                begin bad++; $display("FAIL enable_pulse%0d got=%h exp=%h", i, {pq[i].rs, pq[i].db}, exp[i]); end
        end
        disp[1] = 8'h34;
        pq.delete();
    endtask

    task automatic test_blank();
        logic [3:0] vals[3];
        logic [8:0] exp[$];
        bit ok;
        vals = '{4'd5, 4'd12, 4'd15};
        for (int s = 0; s < 3; s++) begin
            lcd_en = 1'b1; num = 2'd0; lcd_num = vals[s];
            exp.delete();
            if (ch(vals[s]) != disp[0]) begin
                exp.push_back({1'b0, 8'h80}); exp.push_back({1'b1, ch(vals[s])}); disp[0] = ch(vals[s]);
            end
            settle(ok);
            total++; if (!ok || pq.size() != exp.size()) begin bad++; $display("FAIL blank_count%0d got=%0d exp=%0d", s, pq.size(), exp.size()); end
            foreach (exp[i]) if (i < pq.size()) begin
                total++;
                if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE)
                    begin bad++; $display("FAIL blank_pulse%0d_%0d got=%h exp=%h", s, i, {pq[i].rs, pq[i].db}, exp[i]); end
            end
            pq.delete();
        end
    endtask

    task automatic test_mid_pair_change();
        logic [8:0] exp[$];
        bit ok, seen;
        exp = '{9'h082, 9'h131, 9'h083, 9'h139};
        seen = 0;
        lcd_en = 1'b1; num = 2'd2; lcd_num = 4'd1;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge sysclk); if (lcd_e === 1'b1 && lcd_rs === 1'b1) seen = 1; end
        total++; if (!seen) begin bad++; $display("FAIL midpair_wait got=0 exp=1"); end
        num = 2'd3; lcd_num = 4'd9;
        settle(ok);
        total++; if (!ok || pq.size() != 4) begin bad++; $display("FAIL midpair_count got=%0d exp=4", pq.size()); end
        foreach (exp[i]) if (i < pq.size()) begin
            total++;
            if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE || !pq[i].stable)
                begin bad++; $display("FAIL midpair_pulse%0d got=%h exp=%h", i, {pq[i].rs, pq[i].db}, exp[i]); end
        end
        disp[2] = 8'h31; disp[3] = 8'h39;
        pq.delete();
    endtask

    task automatic test_busy();
        logic [8:0] exp[$];
        bit ok;
        lcd_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            busy = (s == 0);
            exp.delete();
`ifdef LCD_DISPLAY_BUSY_IND_EN
            exp.push_back({1'b0, 8'h8F}); exp.push_back({1'b1, busy ? 8'h42 : 8'h20});
            bsh = busy;
`endif
            settle(ok);
            total++; if (!ok || pq.size() != exp.size()) begin bad++; $display("FAIL busy_count%0d got=%0d exp=%0d", s, pq.size(), exp.size()); end
            foreach (exp[i]) if (i < pq.size()) begin
                total++;
                if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE)
                    begin bad++; $display("FAIL busy_pulse%0d_%0d got=%h exp=%h", s, i, {pq[i].rs, pq[i].db}, exp[i]); end
            end
            pq.delete();
        end
    endtask

    task automatic test_random();
        logic [8:0] exp[$];
        bit ok;
        for (int s = 0; s < 40; s++) begin
            lcd_en  = ($urandom_range(0, 3) != 0);
            num     = 2'($urandom_range(0, 3));
            lcd_num = 4'($urandom_range(0, 15));
            busy    = ($urandom_range(0, 2) == 0);
            exp.delete();
            if (lcd_en && ch(lcd_num) != disp[num]) begin
                exp.push_back({1'b0, 8'h80 | {6'b0, num}}); exp.push_back({1'b1, ch(lcd_num)});
                disp[num] = ch(lcd_num);
            end
`ifdef LCD_DISPLAY_BUSY_IND_EN
            if (busy != bsh) begin
                exp.push_back({1'b0, 8'h8F}); exp.push_back({1'b1, busy ? 8'h42 : 8'h20});
                bsh = busy;
            end
`endif
            settle(ok);
            total++; if (!ok || pq.size() != exp.size()) begin bad++; $display("FAIL rand_count%0d got=%0d exp=%0d", s, pq.size(), exp.size()); end
            foreach (exp[i]) if (i < pq.size()) begin
                total++;
                if ({pq[i].rs, pq[i].db} !== exp[i] || pq[i].width != E_PULSE || !pq[i].stable || pq[i].rdy !== 1'b0)
                    begin bad++; $display("FAIL rand_pulse%0d_%0d got=%h w=%0d exp=%h", s, i, {pq[i].rs, pq[i].db}, pq[i].width, exp[i]); end
            end
            pq.delete();
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit seen;
        seen = 0;
        lcd_en = 1'b1; num = 2'd0; busy = 1'b0;
        lcd_num = (disp[0] == 8'h30) ? 4'd1 : 4'd0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge sysclk); if (lcd_e === 1'b1 && lcd_rs === 1'b1) seen = 1; end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_wait got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ready, lcd_rs, lcd_rw, lcd_e, lcd_db} !== 12'h000)
            begin bad++; $display("FAIL rstmid_outs got=%h exp=000", {ready, lcd_rs, lcd_rw, lcd_e, lcd_db}); end
        lcd_en = 1'b0;
        repeat (3) @(negedge sysclk);
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_digit();
        test_disabled();
        test_blank();
        test_mid_pair_change();
        test_busy();
        test_random();
        test_reset_mid_pulse();
        test_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
